// File: rtl/keyboard_matrix_pkg.sv
// Shared constants and types for the keyboard matrix and the PIA1 snoop logic.
package keyboard_matrix_pkg;

  localparam int unsigned KBD_ROW_COUNT     = 10;
  localparam int unsigned KBD_ADDR_WIDTH    = 4;
  localparam int unsigned KBD_ROW_SEL_WIDTH = 4;
  localparam int unsigned PIA_RS_WIDTH      = 2;
  localparam int unsigned PIA_CR_DDR_N_BIT  = 2;

  // Column byte for "no key down" and for rows outside the matrix.
  localparam logic [7:0]  KBD_IDLE          = 8'hFF;

  localparam logic [31:0] WB_REG_BASE       = 32'h0000_0000;
  localparam logic [31:0] WB_KBD_BASE       = 32'h0000_0400;

  // 6520 register select: RS1:RS0.
  typedef enum logic [PIA_RS_WIDTH-1:0] {
    PIA_PORTA = 2'd0,
    PIA_CRA   = 2'd1,
    PIA_PORTB = 2'd2,
    PIA_CRB   = 2'd3
  } pia_rs_e;

  // Bus address of a keyboard row as seen by the MCU.
  function automatic logic [31:0] wb_kbd_addr(input logic [KBD_ADDR_WIDTH-1:0] row);
    return WB_KBD_BASE + 32'(row);
  endfunction

endpackage

// File: rtl/keyboard_matrix_if.sv
// Pipelined Wishbone slave bundle for the keyboard matrix window.
interface keyboard_matrix_if
  import keyboard_matrix_pkg::*;
#(
  parameter int unsigned AW = KBD_ADDR_WIDTH
) ();

  logic [AW-1:0] wb_adr_i;
  logic [7:0]    wb_dat_i;
  logic [7:0]    wb_dat_o;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_ack_o;
  logic          wb_stall_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );

endinterface

// File: rtl/keyboard_matrix_wb_slave_ack.sv
// One-cycle acknowledge generator for a never-stalling pipelined Wishbone slave.
module wb_slave_ack (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_cyc,
  input  logic i_stb,
  output logic o_ack,
  output logic o_stall
);

  logic r_ack;

  // Ack every accepted strobe on the following cycle; cyc dropping later does not cancel it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= i_cyc & i_stb;
    end
  end

  assign o_ack   = r_ack;
  assign o_stall = 1'b0;

endmodule

// File: rtl/keyboard_matrix.sv
// PET 10x8 keyboard matrix: written by the MCU over Wishbone, read by the CPU
// through a snoop of PIA1 (Port A selects the row, Port B returns its columns).
module keyboard_matrix
  import keyboard_matrix_pkg::*;
#(
  parameter int unsigned ROWS = KBD_ROW_COUNT,
  parameter int unsigned AW   = KBD_ADDR_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  keyboard_matrix_if.slave        wb,
  input  logic                    cpu_strobe_i,
  input  logic                    pia1_cs_i,
  input  logic                    cpu_we_i,
  input  logic [PIA_RS_WIDTH-1:0] cpu_rs_i,
  input  logic [7:0]              cpu_data_i,
  output logic [7:0]              cpu_data_o,
  output logic                    cpu_data_oe_o
);

  logic [7:0]                   r_matrix [ROWS];
  logic [KBD_ROW_SEL_WIDTH-1:0] r_row_sel;
  logic                         r_cra_ddr_n;
  logic                         r_crb_ddr_n;
  logic [7:0]                   r_wb_dat;
  logic [7:0]                   r_cpu_data;

  logic       w_wb_accept;
  logic       w_wb_hit;
  logic       w_wb_wr;
  logic       w_wb_rd;
  logic [7:0] w_wb_row;
  logic [7:0] w_sel_row;
  logic       w_snoop_wr;
  pia_rs_e    w_rs;
  logic       w_unused;

  assign w_wb_accept = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_wb_wr     = w_wb_accept & wb.wb_we_i & w_wb_hit;
  assign w_wb_rd     = w_wb_accept & ~wb.wb_we_i;
  assign w_rs        = pia_rs_e'(cpu_rs_i);
  assign w_snoop_wr  = cpu_strobe_i & pia1_cs_i & cpu_we_i;

  // Port A bits 7:4 carry no row information here.
  assign w_unused    = &{1'b0, cpu_data_i[7:KBD_ROW_SEL_WIDTH]};

  // Wishbone address decode: hit flag and row contents, idle byte when out of range.
  always_comb begin
    w_wb_hit = 1'b0;
    w_wb_row = KBD_IDLE;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (wb.wb_adr_i == AW'(i)) begin
        w_wb_hit = 1'b1;
        w_wb_row = r_matrix[i];
      end
    end
  end

  // Row chosen by the CPU, idle byte when row_sel points past the matrix.
  always_comb begin
    w_sel_row = KBD_IDLE;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (r_row_sel == KBD_ROW_SEL_WIDTH'(i)) begin
        w_sel_row = r_matrix[i];
      end
    end
  end

  // Matrix storage, written only by in-range Wishbone writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        r_matrix[i] <= KBD_IDLE;
      end
    end else if (w_wb_wr) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        if (wb.wb_adr_i == AW'(i)) begin
          r_matrix[i] <= wb.wb_dat_i;
        end
      end
    end
  end

  // Wishbone read data, captured on the accept edge and held while ack is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_dat <= KBD_IDLE;
    end else if (w_wb_rd) begin
      r_wb_dat <= w_wb_row;
    end
  end

  // Snoop CPU writes to PIA1: DDR-select bits of both control registers and the Port A row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cra_ddr_n <= 1'b0;
      r_crb_ddr_n <= 1'b0;
      r_row_sel   <= '0;
    end else if (w_snoop_wr) begin
      case (w_rs)
        PIA_CRA:   r_cra_ddr_n <= cpu_data_i[PIA_CR_DDR_N_BIT];
        PIA_CRB:   r_crb_ddr_n <= cpu_data_i[PIA_CR_DDR_N_BIT];
        PIA_PORTA: begin
          // With DDR_N clear the write targets DDRA and leaves the row alone.
          if (r_cra_ddr_n) begin
            r_row_sel <= cpu_data_i[KBD_ROW_SEL_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // CPU column byte, refreshed every cycle from the selected row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cpu_data <= KBD_IDLE;
    end else begin
      r_cpu_data <= w_sel_row;
    end
  end

  assign cpu_data_o    = r_cpu_data;
  assign cpu_data_oe_o = pia1_cs_i & ~cpu_we_i & (w_rs == PIA_PORTB) & r_crb_ddr_n;
  assign wb.wb_dat_o   = r_wb_dat;

  wb_slave_ack u_wb_ack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_cyc   (wb.wb_cyc_i),
    .i_stb   (wb.wb_stb_i),
    .o_ack   (wb.wb_ack_o),
    .o_stall (wb.wb_stall_o)
  );

endmodule

// File: doc/keyboard_matrix.md
# keyboard_matrix

Stores the PET's 10×8 keyboard matrix for the CPU to read. The MCU writes key state over the SPI→Wishbone bridge at `WB_KBD_BASE`. The block snoops CPU accesses to PIA1: it latches the row the CPU selects via Port A and supplies the selected row's column byte when the CPU reads Port B. It sits downstream of the Wishbone address decoder and beside the CPU data bus mux.

## Interface
Parameters:
- `ROWS`, default `KBD_ROW_COUNT` (10): number of matrix rows.
- `AW`, default `KBD_ADDR_WIDTH` (4): Wishbone row-address width.

Ports:
- Clocking and reset (already decided): one clock, `clk_i`; reset `rst_ni`, asynchronous, active-low.
- `clk_i`  in  1  system clock, 64 MHz.
- `rst_ni`  in  1  asynchronous active-low reset.
- `wb_adr_i`  in  AW  row index.
- `wb_dat_i`  in  8  write data; column bits, 0 = key down.
- `wb_dat_o`  out  8  read data.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`  in  1  bus cycle.
- `wb_stb_i`  in  1  strobe; already qualified by the `WB_KBD_BASE` decode.
- `wb_ack_o`  out  1  acknowledge.
- `wb_stall_o`  out  1  tied 0.
- `cpu_strobe_i`  in  1  one-cycle pulse at the CPU bus sample point.
- `pia1_cs_i`  in  1  CPU address decodes to PIA1.
- `cpu_we_i`  in  1  CPU write.
- `cpu_rs_i`  in  `PIA_RS_WIDTH`  PIA register select.
- `cpu_data_i`  in  8  CPU write data.
- `cpu_data_o`  out  8  column byte of the selected row.
- `cpu_data_oe_o`  out  1  block drives the CPU data bus.

## Operation
- State:
  - `matrix[ROWS]`, 8 bits per row.
  - `row_sel`, 4 bits.
  - `cra_ddr_n` and `crb_ddr_n`: snooped copies of PIA control-register bit 2.
- Reset values:
  - every `matrix` row = 8'hFF;
  - `row_sel` = 0;
  - `cra_ddr_n` = `crb_ddr_n` = 0;
  - `wb_ack_o` = 0;
  - `wb_dat_o` = 8'hFF;
  - `cpu_data_o` = 8'hFF;
  - `cpu_data_oe_o` = 0.
- Wishbone slave, pipelined, never stalls:
  - Every `cyc & stb` cycle is accepted.
  - `ack` is returned exactly one cycle later.
  - Back-to-back strobes produce back-to-back acks.
  - Write: `matrix[adr] <= dat_i` on the accept edge.
  - Read: `wb_dat_o <= matrix[adr]` on the accept edge, valid while ack is high.
  - `adr >= ROWS`: write ignored, read returns 8'hFF, still acked.
  - Dropping `cyc` does not cancel an ack already in flight.
- CPU snoop: an event is `cpu_strobe_i & pia1_cs_i`.
  - Write, `rs = PIA_CRA`: `cra_ddr_n <= data[2]`.
  - Write, `rs = PIA_CRB`: `crb_ddr_n <= data[2]`.
  - Write, `rs = PIA_PORTA` with `cra_ddr_n = 1`: `row_sel <= data[3:0]`.
  - Write, `rs = PIA_PORTA` with `cra_ddr_n = 0`: DDR write, ignored.
- CPU read path:
  - `cpu_data_oe_o` = `pia1_cs_i & ~cpu_we_i & rs == PIA_PORTB & crb_ddr_n` (combinational).
  - `cpu_data_o` = `matrix[row_sel]`, or 8'hFF if `row_sel >= ROWS`; registered every cycle.
- The row/column field mapping of Port A bits 7:4 is not handled here; those bits are ignored.

## Timing
- Wishbone latency: 1 cycle from accept to `ack`; throughput 1 transfer per cycle.
- Wishbone write to the selected row: visible on `cpu_data_o` 2 edges after the accept edge (1 to update `matrix`, 1 for the output register).
- Port A write: new row visible on `cpu_data_o` 1 cycle after the next edge following the strobe. This is ≤ 32 ns, far inside the 6502 cycle.
- Same-cycle Wishbone write and CPU Port A write: both take effect. `cpu_data_o` reflects the new row with the new data 2 edges later.
- Same-cycle Wishbone write and Wishbone read of the same row are impossible, because there is one access per cycle.
- Reset mid-transaction: the pending ack is dropped, the matrix returns to all-FF, and the master must retry.

## Structure
- Use the existing shared-package constants `KBD_ROW_COUNT`, `KBD_ADDR_WIDTH`, `PIA_RS_WIDTH`, `PIA_PORTA/CRA/PORTB/CRB`, `wb_kbd_addr()`.
- Add to the shared package: `PIA_CR_DDR_N_BIT = 2`, `KBD_ROW_SEL_WIDTH = 4`, `KBD_IDLE = 8'hFF`.
- Optional sub-module `wb_slave_ack`: one-cycle ack/stall generator, reusable by the register block at `WB_REG_BASE`.
- `matrix` maps to distributed registers; no block RAM is needed at 10 bytes.

## Test plan
- Reset → all 10 rows read back 8'hFF over Wishbone; `cpu_data_oe_o` = 0; ack arrives 1 cycle after strobe.
- Wishbone write row 3 = 8'hFE, then read row 3 → `wb_dat_o` = 8'hFE with ack. Write row 12 = 8'h00 → read row 12 returns 8'hFF.
- CPU writes CRA = 8'h04, then Port A = 8'hF3; CPU writes CRB = 8'h04, then reads Port B → `cpu_data_oe_o` = 1, `cpu_data_o` = 8'hFE.
- With CRA bit 2 = 0, CPU writes Port A = 8'h05 → `row_sel` unchanged, read still returns row 3. Select row 15 → read 8'hFF.
- Wishbone writes the selected row to 8'h7F in the same cycle as a CPU Port A strobe reselecting row 3 → `cpu_data_o` = 8'h7F exactly 2 edges later.
- 4 back-to-back Wishbone writes, with `rst_ni` asserted during the 3rd → no ack after reset; rows 0–3 = 8'hFF; `row_sel` = 0.
